red_pitaya_boxcar_block: RTL and testbench



---
 rtl/red_pitaya_boxcar_block.sv | 198 +++++++++++++++++++
 tb/tb_red_pitaya_boxcar_block.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/red_pitaya_boxcar_block.sv
// Triggered boxcar integrator: after a programmable delay it sums a window of
// samples, then publishes the raw sum and a shifted, saturated copy on dat_o.
module red_pitaya_boxcar_block #(
    parameter int DATABITS   = 14,
    parameter int WINDOWBITS = 16
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic signed [DATABITS-1:0] dat_i,
    input  logic                       trig_i,
    output logic signed [DATABITS-1:0] dat_o,
    output logic                       done_o,
    output logic                       busy_o,
    input  logic [15:0]                addr,
    input  logic                       wen,
    input  logic                       ren,
    output logic                       ack,
    output logic [31:0]                rdata,
    input  logic [31:0]                wdata
);

    localparam int ACCBITS = DATABITS + WINDOWBITS;
    localparam logic signed [ACCBITS-1:0] SAT_HI = ACCBITS'(2**(DATABITS-1) - 1);
    localparam logic signed [ACCBITS-1:0] SAT_LO = ~SAT_HI;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_DELAY     = 2'd1,
        ST_INTEGRATE = 2'd2,
        ST_DONE      = 2'd3
    } state_t;

    state_t                     state_q, state_d;
    logic [31:0]                cnt_q, cnt_d;
    logic [31:0]                delay_q, delay_d;
    logic [WINDOWBITS-1:0]      window_q, window_d;
    logic [3:0]                 shift_q, shift_d;
    logic [31:0]                delay_sh_q, delay_sh_d;
    logic [WINDOWBITS-1:0]      win_sh_q, win_sh_d;
    logic signed [ACCBITS-1:0]  acc_q, acc_d;
    logic signed [ACCBITS-1:0]  sum_q, sum_d;
    logic signed [DATABITS-1:0] dat_o_q, dat_o_d;
    logic                       done_q, done_d;
    logic [31:0]                completed_q, completed_d;
    logic [31:0]                missed_q, missed_d;
    logic                       ack_q, ack_d;
    logic [31:0]                rdata_q, rdata_d;

    logic                       abort;
    logic                       last_delay;
    logic                       last_win;
    logic signed [ACCBITS-1:0]  shifted;
    logic signed [DATABITS-1:0] dat_sat;

    assign abort      = wen && (addr == 16'h0100);
    assign last_delay = (cnt_q == delay_sh_q - 32'd1);
    assign last_win   = (cnt_q == 32'(win_sh_q) - 32'd1);
    assign shifted    = acc_q >>> shift_q;
    assign dat_sat    = (shifted > SAT_HI) ? SAT_HI[DATABITS-1:0] :
                        (shifted < SAT_LO) ? SAT_LO[DATABITS-1:0] :
                                             shifted[DATABITS-1:0];

    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples the pre-edge value of every other flop regardless of block order.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // Abort wins over everything, including a trigger in the same cycle.
    always_comb begin
        state_d = state_q;
        if (abort) begin
            state_d = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE:      if (trig_i) state_d = (delay_q != 32'd0) ? ST_DELAY : ST_INTEGRATE;
                ST_DELAY:     if (last_delay) state_d = ST_INTEGRATE;
                ST_INTEGRATE: if (last_win) state_d = ST_DONE;
                ST_DONE:      state_d = ST_IDLE;
                default:      state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        busy_o = (state_q == ST_DELAY) || (state_q == ST_INTEGRATE);
    end

    // NOTE: every variable gets its hold value first, so no path leaves one
    // unassigned and no latch is inferred.
    always_comb begin
        cnt_d       = cnt_q;
        delay_d     = delay_q;
        window_d    = window_q;
        shift_d     = shift_q;
        delay_sh_d  = delay_sh_q;
        win_sh_d    = win_sh_q;
        acc_d       = acc_q;
        sum_d       = sum_q;
        dat_o_d     = dat_o_q;
        done_d      = 1'b0;
        completed_d = completed_q;
        missed_d    = missed_q;
        ack_d       = wen | ren;
        rdata_d     = rdata_q;

        if (!abort) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (trig_i) begin
                        delay_sh_d = delay_q;
                        win_sh_d   = (window_q == '0) ? WINDOWBITS'(1) : window_q;
                        acc_d      = '0;
                        cnt_d      = '0;
                    end
                end
                ST_DELAY: begin
                    cnt_d = last_delay ? 32'd0 : cnt_q + 32'd1;
                end
                ST_INTEGRATE: begin
                    acc_d = acc_q + $signed({{WINDOWBITS{dat_i[DATABITS-1]}}, dat_i});
                    cnt_d = last_win ? 32'd0 : cnt_q + 32'd1;
                end
                ST_DONE: begin
                    sum_d       = acc_q;
                    dat_o_d     = dat_sat;
                    done_d      = 1'b1;
                    completed_d = completed_q + 32'd1;
                end
                default: ;
            endcase
            if (trig_i && state_q != ST_IDLE) missed_d = missed_q + 32'd1;
        end

        if (wen) begin
            unique case (addr)
                16'h0104: delay_d  = wdata;
                16'h0108: window_d = wdata[WINDOWBITS-1:0];
                16'h010C: shift_d  = wdata[3:0];
                default: ;
            endcase
        end

        if (ren) begin
            unique case (addr)
                16'h0100: rdata_d = {30'd0, state_q};
                16'h0104: rdata_d = delay_q;
                16'h0108: rdata_d = {{(32-WINDOWBITS){1'b0}}, window_q};
                16'h010C: rdata_d = {28'd0, shift_q};
                16'h0110: rdata_d = {{(32-ACCBITS){sum_q[ACCBITS-1]}}, sum_q};
                16'h0114: rdata_d = completed_q;
                16'h0118: rdata_d = missed_q;
                default:  rdata_d = 32'd0;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q       <= '0;
            delay_q     <= '0;
            window_q    <= WINDOWBITS'(1);
            shift_q     <= '0;
            delay_sh_q  <= '0;
            win_sh_q    <= WINDOWBITS'(1);
            acc_q       <= '0;
            sum_q       <= '0;
            dat_o_q     <= '0;
            done_q      <= 1'b0;
            completed_q <= '0;
            missed_q    <= '0;
            ack_q       <= 1'b0;
            rdata_q     <= '0;
        end else begin
            cnt_q       <= cnt_d;
            delay_q     <= delay_d;
            window_q    <= window_d;
            shift_q     <= shift_d;
            delay_sh_q  <= delay_sh_d;
            win_sh_q    <= win_sh_d;
            acc_q       <= acc_d;
            sum_q       <= sum_d;
            dat_o_q     <= dat_o_d;
            done_q      <= done_d;
            completed_q <= completed_d;
            missed_q    <= missed_d;
            ack_q       <= ack_d;
            rdata_q     <= rdata_d;
        end
    end

    assign dat_o  = dat_o_q;
    assign done_o = done_q;
    assign ack    = ack_q;
    assign rdata  = rdata_q;

endmodule

// File: tb/tb_red_pitaya_boxcar_block.sv
// Directed bench for the boxcar block; expected values are worked out by hand
// from the documented timing (trigger edge k, done at k+delay+window+1).
module tb_red_pitaya_boxcar_block;

    logic               clk_i = 1'b0;
    logic               rst_i;
    logic signed [13:0] dat_i;
    logic               trig_i;
    logic signed [13:0] dat_o;
    logic               done_o;
    logic               busy_o;
    logic [15:0]        addr;
    logic               wen;
    logic               ren;
    logic               ack;
    logic [31:0]        rdata;
    logic [31:0]        wdata;

    int n_pass  = 0;
    int n_total = 0;

    red_pitaya_boxcar_block dut (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .dat_i  (dat_i),
        .trig_i (trig_i),
        .dat_o  (dat_o),
        .done_o (done_o),
        .busy_o (busy_o),
        .addr   (addr),
        .wen    (wen),
        .ren    (ren),
        .ack    (ack),
        .rdata  (rdata),
        .wdata  (wdata)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic bus_write(input logic [15:0] a, input logic [31:0] d);
        addr  = a;
        wdata = d;
        wen   = 1'b1;
        tick();
        wen   = 1'b0;
    endtask

    task automatic bus_read(input logic [15:0] a, output logic [31:0] d);
        addr = a;
        ren  = 1'b1;
        tick();
        ren  = 1'b0;
        d    = rdata;
    endtask

    task automatic pulse_trig();
        trig_i = 1'b1;
        tick();
        trig_i = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        for (int i = 0; i < 200 && !done_o; i++) tick();
        check(tag, {31'd0, done_o}, 32'd1);
    endtask

    initial begin
        logic [31:0] rd;
        int          busy_cnt;
        int          done_cnt;
        int          done_at;

        rst_i  = 1'b1;
        dat_i  = '0;
        trig_i = 1'b0;
        addr   = '0;
        wen    = 1'b0;
        ren    = 1'b0;
        wdata  = '0;
        repeat (3) tick();
        check("rst_dat_o", {18'd0, dat_o}, 32'd0);
        check("rst_busy", {31'd0, busy_o}, 32'd0);
        check("rst_done", {31'd0, done_o}, 32'd0);
        check("rst_ack", {31'd0, ack}, 32'd0);
        check("rst_rdata", rdata, 32'd0);
        rst_i = 1'b0;
        tick();
        bus_read(16'h0108, rd);
        check("rst_window", rd, 32'd1);
        check("read_ack", {31'd0, ack}, 32'd1);
        bus_read(16'h0100, rd);
        check("rst_state", rd, 32'd0);
        bus_read(16'h0200, rd);
        check("unmapped_read", rd, 32'd0);

        // Basic run: delay 3, window 4, shift 2, constant 100.
        bus_write(16'h0104, 32'd3);
        bus_write(16'h0108, 32'd4);
        bus_write(16'h010C, 32'd2);
        dat_i = 14'sd100;
        pulse_trig();
        busy_cnt = 0;
        done_cnt = 0;
        done_at  = -1;
        for (int i = 1; i <= 12; i++) begin
            if (busy_o) busy_cnt++;
            tick();
            if (done_o) begin
                done_cnt++;
                if (done_at < 0) done_at = i;
            end
        end
        check("t1_busy_cycles", 32'(busy_cnt), 32'd7);
        check("t1_done_edge", 32'(done_at), 32'd8);
        check("t1_done_count", 32'(done_cnt), 32'd1);
        check("t1_dat_o", {18'd0, dat_o}, 32'd100);
        bus_read(16'h0110, rd);
        check("t1_sum", rd, 32'd400);
        bus_read(16'h0114, rd);
        check("t1_completed", rd, 32'd1);

        // Positive saturation.
        bus_write(16'h0104, 32'd0);
        bus_write(16'h0108, 32'd16);
        bus_write(16'h010C, 32'd0);
        dat_i = 14'sd8191;
        pulse_trig();
        wait_done("t2_done");
        check("t2_dat_o", {18'd0, dat_o}, 32'h1FFF);
        bus_read(16'h0110, rd);
        check("t2_sum", rd, 32'd131056);

        // Negative saturation.
        bus_write(16'h0108, 32'd4);
        dat_i = -14'sd8192;
        pulse_trig();
        wait_done("t3_done");
        check("t3_dat_o", {18'd0, dat_o}, 32'h2000);
        bus_read(16'h0110, rd);
        check("t3_sum", rd, 32'hFFFF8000);

        // Ramp: sample n present at edge n, trigger at edge 10.
        bus_write(16'h0104, 32'd2);
        bus_write(16'h0108, 32'd3);
        done_cnt = 0;
        done_at  = -1;
        for (int n = 0; n <= 24; n++) begin
            dat_i  = 14'(n);
            trig_i = (n == 10);
            tick();
            if (done_o) begin
                done_cnt++;
                done_at = n;
            end
        end
        trig_i = 1'b0;
        check("t4_done_edge", 32'(done_at), 32'd16);
        check("t4_dat_o", {18'd0, dat_o}, 32'd42);
        bus_read(16'h0110, rd);
        check("t4_sum", rd, 32'd42);

        // Extra triggers during INTEGRATE (k+3) and DONE (k+6) are missed.
        bus_write(16'h0104, 32'd1);
        bus_write(16'h0108, 32'd4);
        dat_i    = 14'sd5;
        done_cnt = 0;
        for (int i = 0; i <= 15; i++) begin
            trig_i = (i == 0) || (i == 3) || (i == 6);
            tick();
            if (done_o) done_cnt++;
        end
        trig_i = 1'b0;
        check("t5_done_count", 32'(done_cnt), 32'd1);
        bus_read(16'h0118, rd);
        check("t5_missed", rd, 32'd2);
        bus_read(16'h0110, rd);
        check("t5_sum", rd, 32'd20);
        bus_read(16'h0100, rd);
        check("t5_state_idle", rd, 32'd0);
        bus_read(16'h0114, rd);
        check("t5_completed", rd, 32'd5);

        // Window 0 acts as 1.
        bus_write(16'h0104, 32'd2);
        bus_write(16'h0108, 32'd0);
        bus_read(16'h0108, rd);
        check("t6_window_raw", rd, 32'd0);
        dat_i = 14'sd7;
        pulse_trig();
        wait_done("t6_done");
        bus_read(16'h0110, rd);
        check("t6_sum", rd, 32'd7);

        // Window rewritten during DELAY does not affect the current run.
        dat_i = 14'sd3;
        pulse_trig();
        bus_write(16'h0108, 32'd8);
        check("t7_busy_in_delay", {31'd0, busy_o}, 32'd1);
        wait_done("t7_done");
        check("t7_dat_o", {18'd0, dat_o}, 32'd3);
        bus_read(16'h0110, rd);
        check("t7_sum", rd, 32'd3);
        bus_read(16'h0114, rd);
        check("t7_completed", rd, 32'd7);

        // Abort at the second INTEGRATE cycle.
        bus_write(16'h0104, 32'd0);
        dat_i = 14'sd1;
        pulse_trig();
        tick();
        bus_write(16'h0100, 32'd0);
        check("t8_busy_after_abort", {31'd0, busy_o}, 32'd0);
        bus_read(16'h0100, rd);
        check("t8_state", rd, 32'd0);
        done_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done_o) done_cnt++;
        end
        check("t8_no_done", 32'(done_cnt), 32'd0);
        check("t8_dat_o_held", {18'd0, dat_o}, 32'd3);
        bus_read(16'h0114, rd);
        check("t8_completed", rd, 32'd7);
        bus_read(16'h0118, rd);
        check("t8_missed", rd, 32'd2);
        bus_read(16'h0110, rd);
        check("t8_sum_held", rd, 32'd3);

        // Reset during DELAY.
        bus_write(16'h0104, 32'd5);
        pulse_trig();
        tick();
        check("t9_busy_pre_rst", {31'd0, busy_o}, 32'd1);
        rst_i = 1'b1;
        #1;
        check("t9_busy", {31'd0, busy_o}, 32'd0);
        check("t9_dat_o", {18'd0, dat_o}, 32'd0);
        check("t9_done", {31'd0, done_o}, 32'd0);
        check("t9_rdata", rdata, 32'd0);
        tick();
        rst_i = 1'b0;
        bus_read(16'h0108, rd);
        check("t9_window", rd, 32'd1);
        bus_read(16'h0104, rd);
        check("t9_delay", rd, 32'd0);
        bus_read(16'h0114, rd);
        check("t9_completed", rd, 32'd0);
        done_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (done_o) done_cnt++;
        end
        check("t9_no_done", 32'(done_cnt), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
